alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequencer between the multi-cycle control unit and the shared `alu` datapath. It accepts one ALU operation at a time over a valid/ready handshake and drives stable operands and a 4-bit ALUControl into the ALU. It holds those values for a per-class latency so multicycle MUL/DIV/FP paths settle, then captures the results. It returns them to the register file over a writeback handshake, using two beats for UMULL/SMULL (RdLo, then RdHi).

Parameters:
LAT_ALU, 1, EXEC cycles for ADD/SUB/AND/ORR/MOV (ctrl 000x, 0010, 0011, 1100); min 1
LAT_MUL, 3, EXEC cycles for MUL/UMULL/SMULL (0100, 0101, 0110); min 1
LAT_DIV, 8, EXEC cycles for DIV (0111); min 1
LAT_FP, 4, EXEC cycles for FPADD32/FPADD16 (1000, 1001); min 1
CNT_W, 4, latency counter width; must hold max(LAT_*)-1

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  synchronous abort of in-flight op
req_valid  in  1  request present
req_ready  out  1  ctrl can accept
req_op  in  4  ALUControl encoding
req_a  in  32  operand a
req_b  in  32  operand b
req_rd_lo  in  4  dest reg (result / RdLo)
req_rd_hi  in  4  dest reg RdHi (UMULL/SMULL only)
req_setflags  in  1  S bit
alu_a  out  32  to alu.a
alu_b  out  32  to alu.b
alu_ctrl  out  4  to alu.ALUControl
alu_result  in  32  from alu.Result
alu_result2  in  32  from alu.Result2
alu_flags  in  4  from alu.ALUFlags {N,Z,C,V}
wb_valid  out  1  writeback beat present
wb_ready  in  1  regfile accepts beat
wb_rd  out  4  dest register
wb_data  out  32  write data
wb_flags_we  out  1  flag update on this beat
wb_flags  out  4  NZCV
illegal_op  out  1  1-cycle pulse: rejected encoding
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, EXEC, WB_LO, WB_HI. Reset (reset==0 at edge) → IDLE. All outputs 0, all internal registers 0.
- req_ready = (state==IDLE) & ~flush. Accept = req_valid & req_ready.
- On accept of a legal op:
  - latch a, b, op, rd_lo, rd_hi, setflags;
  - load counter with LAT_class-1;
  - go to EXEC.
- Illegal ops (1010, 1011, 1101, 1110, 1111): accepted, illegal_op=1 next cycle, remain IDLE, no writeback.
- alu_a/alu_b/alu_ctrl: driven from latched registers only, constant from the accept edge until returning to IDLE. Driven 0 in IDLE.
- EXEC: counter decrements each cycle. When counter==0:
  - capture alu_result→res_lo, alu_result2→res_hi, alu_flags→flg;
  - go to WB_LO.
  - Accept-to-wb_valid latency = LAT_class+1 cycles.
- WB_LO: wb_valid=1, wb_rd=rd_lo, wb_data=res_lo. Beat completes on wb_ready:
  - UMULL/SMULL → WB_HI;
  - all other ops → IDLE.
- WB_HI: wb_valid=1, wb_rd=rd_hi, wb_data=res_hi. On wb_ready → IDLE.
- wb_flags = flg. wb_flags_we = wb_valid & setflags & final beat (WB_HI for long mul, WB_LO otherwise).
- wb_valid held with stable rd/data/flags until wb_ready; back-pressure unbounded.
- rd_lo==rd_hi on long mul: both beats still issued, hi beat last; no merging.
- Minimum occupancy: 1 (accept) + LAT + 1 (WB) cycles. req_ready rises the cycle after the final beat completes; no same-cycle re-accept.
- flush=1: next state IDLE from any state, pending result discarded, no wb beat, counter cleared. flush overrides a simultaneous wb_ready (that beat counts as not delivered) and blocks acceptance.
- reset mid-operation: same as flush, plus illegal_op cleared.
- DIV with b==0: issued to ALU normally, result is whatever alu_result returns unless ALU_DIVZERO_TRAP_EN is defined.

Optional Feature:
Macro ALU_DIVZERO_TRAP_EN.
- Defined: on accept of DIV with req_b==0:
  - no EXEC;
  - add output div_zero (1 bit, reset 0), pulsed for one cycle after accept;
  - state stays IDLE, no writeback, alu_ctrl not driven with 0111.
- Undefined: port absent; DIV by zero sequenced like any DIV.

Test Plan:
- ADD (0000), a=5, b=7, rd_lo=3, S=1, wb_ready=1 → wb_valid 2 cycles after accept; wb_rd=3, wb_data=12, wb_flags=0000, wb_flags_we=1.
- UMULL (0101), a=0xFFFFFFFF, b=2, rd_lo=4, rd_hi=5, LAT_MUL=3 → beat1 rd=4 data=0xFFFFFFFE; beat2 rd=5 data=0x00000001; flags_we only on beat2.
- DIV, a=100, b=7, LAT_DIV=8, wb_ready low 5 cycles → wb_valid first at accept+9, held stable, data=14 delivered when wb_ready rises; req_ready low throughout.
- Illegal op 1011 → illegal_op pulse, busy stays 0, no wb_valid; next ADD accepted the following cycle.
- flush in cycle 2 of SMULL EXEC → IDLE next cycle, no wb beats; reset=0 during WB_HI → all outputs 0 next cycle.
- With ALU_DIVZERO_TRAP_EN: DIV b=0 → div_zero pulse, no wb_valid; without the macro: one wb beat with ALU result.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Sequencer between the multi-cycle control unit and the shared ALU
//   datapath. Accepts one ALU operation at a time, holds stable operands and
//   ALUControl on the ALU for a per-class latency, captures the results, and
//   returns them to the register file over a writeback handshake. UMULL/SMULL
//   return two beats (RdLo first, then RdHi).
//
// Optional build macro:
//   ALU_DIVZERO_TRAP_EN - when defined, a DIV with req_b==0 is rejected at
//                         accept time and reported on the extra div_zero port
//                         instead of being issued to the ALU.
//
// Ports:
//   clk, reset (sync, active-low), flush (sync abort)
//   req_valid/req_ready, req_op, req_a, req_b, req_rd_lo, req_rd_hi,
//   req_setflags                 : request handshake from control unit
//   alu_a, alu_b, alu_ctrl       : stable operands / ALUControl to the ALU
//   alu_result, alu_result2,
//   alu_flags                    : ALU outputs sampled at end of EXEC
//   wb_valid/wb_ready, wb_rd, wb_data, wb_flags_we, wb_flags
//                                : writeback beats to the register file
//   illegal_op                   : 1-cycle pulse for a rejected encoding
//   div_zero                     : 1-cycle pulse for trapped DIV by zero
//                                  (only with ALU_DIVZERO_TRAP_EN)
//   busy                         : controller not in IDLE
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int unsigned LAT_ALU = 1,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 8,
  parameter int unsigned LAT_FP  = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_rd_lo,
  input  logic [3:0]  req_rd_hi,
  input  logic        req_setflags,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_result2,
  input  logic [3:0]  alu_flags,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_flags_we,
  output logic [3:0]  wb_flags,
  output logic        illegal_op,
`ifdef ALU_DIVZERO_TRAP_EN
  output logic        div_zero,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_WB_LO = 2'd2,
    S_WB_HI = 2'd3
  } state_t;

  localparam logic [3:0] OP_DIV = 4'b0111;

  // ---------------------------------------------------------------------------
  // Encoding helpers
  // ---------------------------------------------------------------------------

  // Encodings the ALU implements; everything else is rejected.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1100: ok = 1'b1;
      4'b0100, 4'b0101, 4'b0110:                   ok = 1'b1;
      4'b0111:                                     ok = 1'b1;
      4'b1000, 4'b1001:                            ok = 1'b1;
      default:                                     ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Counter preload: EXEC lasts (value+1) cycles, i.e. LAT_class cycles.
  function automatic logic [CNT_W-1:0] op_lat_m1(input logic [3:0] op);
    logic [CNT_W-1:0] lat;
    case (op)
      4'b0100, 4'b0101, 4'b0110: lat = CNT_W'(LAT_MUL - 1);
      4'b0111:                   lat = CNT_W'(LAT_DIV - 1);
      4'b1000, 4'b1001:          lat = CNT_W'(LAT_FP - 1);
      default:                   lat = CNT_W'(LAT_ALU - 1);
    endcase
    return lat;
  endfunction

  // UMULL/SMULL produce a 64-bit result returned in two beats.
  function automatic logic op_long_mul(input logic [3:0] op);
    return (op == 4'b0101) || (op == 4'b0110);
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [3:0]       r_op;
  logic [3:0]       r_rd_lo;
  logic [3:0]       r_rd_hi;
  logic             r_setflags;
  logic [31:0]      r_res_lo;
  logic [31:0]      r_res_hi;
  logic [3:0]       r_flg;
  logic             r_illegal;
  logic             r_div_zero;

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_capture;
  logic             w_req_ready;
  logic             w_accept;
  logic             w_legal;
  logic             w_trap;
  logic             w_start;
  logic             w_busy;
  logic             w_long;
  logic             w_in_lo;
  logic             w_in_hi;

  // Holding reset low also closes the request port so every output reads 0.
  assign w_req_ready = (r_state == S_IDLE) & ~flush & reset;
  assign w_accept    = req_valid & w_req_ready;
  assign w_legal     = op_legal(req_op);

`ifdef ALU_DIVZERO_TRAP_EN
  assign w_trap = (req_op == OP_DIV) && (req_b == 32'd0);
`else
  assign w_trap = 1'b0;
`endif

  // Only legal, non-trapped ops occupy the ALU.
  assign w_start = w_accept & w_legal & ~w_trap;
  assign w_busy  = (r_state != S_IDLE);
  assign w_long  = op_long_mul(r_op);
  assign w_in_lo = (r_state == S_WB_LO);
  assign w_in_hi = (r_state == S_WB_HI);

  // Next-state, counter and capture decode; flush wins over every transition.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_capture    = 1'b0;
    if (flush) begin
      w_next_state = S_IDLE;
      w_next_cnt   = {CNT_W{1'b0}};
      w_capture    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            w_next_state = S_EXEC;
            w_next_cnt   = op_lat_m1(req_op);
          end else begin
            w_next_state = S_IDLE;
            w_next_cnt   = {CNT_W{1'b0}};
          end
        end
        S_EXEC: begin
          if (r_cnt == {CNT_W{1'b0}}) begin
            w_next_state = S_WB_LO;
            w_capture    = 1'b1;
          end else begin
            w_next_cnt   = r_cnt - CNT_W'(1);
          end
        end
        S_WB_LO: begin
          if (wb_ready) begin
            w_next_state = w_long ? S_WB_HI : S_IDLE;
          end else begin
            w_next_state = S_WB_LO;
          end
        end
        S_WB_HI: begin
          if (wb_ready) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_WB_HI;
          end
        end
        default: begin
          w_next_state = S_IDLE;
          w_next_cnt   = {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  // Request latch, result capture and status pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_op       <= 4'd0;
      r_rd_lo    <= 4'd0;
      r_rd_hi    <= 4'd0;
      r_setflags <= 1'b0;
      r_res_lo   <= 32'd0;
      r_res_hi   <= 32'd0;
      r_flg      <= 4'd0;
      r_illegal  <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      if (w_start) begin
        r_a        <= req_a;
        r_b        <= req_b;
        r_op       <= req_op;
        r_rd_lo    <= req_rd_lo;
        r_rd_hi    <= req_rd_hi;
        r_setflags <= req_setflags;
      end
      // A flushed result must never be written back later.
      if (flush) begin
        r_res_lo <= 32'd0;
        r_res_hi <= 32'd0;
        r_flg    <= 4'd0;
      end else if (w_capture) begin
        r_res_lo <= alu_result;
        r_res_hi <= alu_result2;
        r_flg    <= alu_flags;
      end
      r_illegal  <= w_accept & ~w_legal;
      r_div_zero <= w_accept & w_legal & w_trap;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: ALU drive is gated so IDLE presents zeros, never stale operands.
  // ---------------------------------------------------------------------------
  assign req_ready   = w_req_ready;
  assign alu_a       = w_busy ? r_a    : 32'd0;
  assign alu_b       = w_busy ? r_b    : 32'd0;
  assign alu_ctrl    = w_busy ? r_op   : 4'd0;
  assign wb_valid    = w_in_lo | w_in_hi;
  assign wb_rd       = w_in_lo ? r_rd_lo  : (w_in_hi ? r_rd_hi  : 4'd0);
  assign wb_data     = w_in_lo ? r_res_lo : (w_in_hi ? r_res_hi : 32'd0);
  assign wb_flags    = r_flg;
  // Flags are written once, on the final beat of the op.
  assign wb_flags_we = r_setflags & ((w_in_lo & ~w_long) | w_in_hi);
  assign illegal_op  = r_illegal;
  assign busy        = w_busy;

`ifdef ALU_DIVZERO_TRAP_EN
  assign div_zero = r_div_zero;
`else
  // Trap pulse exists only in the trap build; keep the register tied off.
  logic w_div_zero_unused;
  assign w_div_zero_unused = r_div_zero;
`endif

endmodule
